// File: rtl/pmu_pkg.sv
// Shared types and header field layout for the PMU key deserializer.
package pmu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        KEY,
        HOLD,
        WAIT_LOW
    } pmu_state_e;

    localparam logic [7:0] LOAD_OPCODE_DEF = 8'hA5;

    localparam int OPC_LSB = 0;
    localparam int LEN_LSB = 8;
    localparam int FLD_W   = 8;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pmu_key_deserializer_if.sv
// Serial key-load bus: framed bit stream in, parallel key out with valid/ready.
interface pmu_key_if #(
    parameter int KEY_WIDTH = 256
);
    logic                 data_i;
    logic                 en;
    logic [KEY_WIDTH-1:0] key_o;
    logic                 key_valid;
    logic                 key_ready;
    logic                 busy;
    logic                 hdr_err;
    logic                 frame_abort;

    modport master (
        input  data_i, en, key_ready,
        output key_o, key_valid, busy, hdr_err, frame_abort
    );

    modport slave (
        output data_i, en, key_ready,
        input  key_o, key_valid, busy, hdr_err, frame_abort
    );
endinterface

// File: rtl/pmu_key_deserializer_shifter.sv
// Indexed bit-capture register: writes one bit at idx_i per load, clear has priority.
// Latency 1 cycle; no backpressure, the caller owns sequencing.
module pmu_serial_shifter #(
    parameter int WIDTH = 32,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             ld_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr_i) begin
            q_d = '0;
        end else if (ld_i) begin
            q_d[idx_i] = bit_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/pmu_key_deserializer.sv
// Serial-to-parallel key loader: header check, key presented 1 cycle after its last bit, held until key_ready.
// PMU_KEY_ZEROIZE_EN clears key_o and the shadow after delivery (and the shadow on header errors).
module pmu_key_deserializer
    import pmu_pkg::*;
#(
    parameter int          HEADER_WIDTH = 32,
    parameter int          KEY_WIDTH    = 256,
    parameter logic [7:0]  LOAD_OPCODE  = LOAD_OPCODE_DEF
) (
    input logic     clk,
    input logic     rst,
    pmu_key_if.master bus
);

    localparam int CW  = $clog2(max_int(HEADER_WIDTH, KEY_WIDTH));
    localparam int HIW = $clog2(HEADER_WIDTH);
    localparam int KIW = $clog2(KEY_WIDTH);
    localparam logic [FLD_W-1:0] LEN_WORDS = FLD_W'(KEY_WIDTH / 32);

    pmu_state_e           state_q;
    logic [CW-1:0]        cnt_q;
    logic [KEY_WIDTH-1:0] key_q;
    logic                 key_valid_q;
    logic                 busy_q;
    logic                 hdr_err_q;
    logic                 frame_abort_q;

    logic                    hdr_ld, hdr_clr, key_ld, key_clr;
    logic [HIW-1:0]          hdr_idx;
    logic [HEADER_WIDTH-1:0] hdr_q, hdr_full;
    logic [KEY_WIDTH-1:0]    shd_q, key_full;
    logic                    hdr_last, key_last, hdr_ok;
    logic                    unused_bits;

    // The final bit is merged combinationally so the check/copy happens on the edge that samples it.
    assign hdr_full = {bus.data_i, hdr_q[HEADER_WIDTH-2:0]};
    assign key_full = {bus.data_i, shd_q[KEY_WIDTH-2:0]};
    assign hdr_last = (state_q == HEADER) && bus.en && (cnt_q == CW'(HEADER_WIDTH - 1));
    assign key_last = (state_q == KEY) && bus.en && (cnt_q == CW'(KEY_WIDTH - 1));
    assign hdr_ok   = (hdr_full[OPC_LSB +: FLD_W] == LOAD_OPCODE) &&
                      (hdr_full[LEN_LSB +: FLD_W] == LEN_WORDS);
    assign unused_bits = ^{hdr_q[HEADER_WIDTH-1], shd_q[KEY_WIDTH-1],
                           hdr_full[HEADER_WIDTH-1:2*FLD_W]};

    always_comb begin
        hdr_ld  = 1'b0;
        hdr_clr = 1'b0;
        key_ld  = 1'b0;
        key_clr = 1'b0;
        hdr_idx = cnt_q[HIW-1:0];
        unique case (state_q)
            IDLE: begin
                hdr_ld  = bus.en;
                hdr_idx = '0;
            end
            HEADER: begin
                hdr_ld  = bus.en;
                hdr_clr = !bus.en;
`ifdef PMU_KEY_ZEROIZE_EN
                key_clr = hdr_last && !hdr_ok;
`endif
            end
            KEY: begin
                key_ld  = bus.en;
                key_clr = !bus.en;
            end
            HOLD: begin
`ifdef PMU_KEY_ZEROIZE_EN
                key_clr = bus.key_ready;
`endif
            end
            default: begin
            end
        endcase
    end

    pmu_serial_shifter #(.WIDTH(HEADER_WIDTH), .IDX_W(HIW)) u_hdr (
        .clk   (clk),
        .rst   (rst),
        .clr_i (hdr_clr),
        .ld_i  (hdr_ld),
        .idx_i (hdr_idx),
        .bit_i (bus.data_i),
        .q_o   (hdr_q)
    );

    pmu_serial_shifter #(.WIDTH(KEY_WIDTH), .IDX_W(KIW)) u_key (
        .clk   (clk),
        .rst   (rst),
        .clr_i (key_clr),
        .ld_i  (key_ld),
        .idx_i (cnt_q[KIW-1:0]),
        .bit_i (bus.data_i),
        .q_o   (shd_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            key_q         <= '0;
            key_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            hdr_err_q     <= 1'b0;
            frame_abort_q <= 1'b0;
        end else begin
            hdr_err_q     <= 1'b0;
            frame_abort_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.en) begin
                        state_q <= HEADER;
                        cnt_q   <= CW'(1);
                        busy_q  <= 1'b1;
                    end
                end
                HEADER: begin
                    if (!bus.en) begin
                        state_q       <= IDLE;
                        cnt_q         <= '0;
                        busy_q        <= 1'b0;
                        frame_abort_q <= 1'b1;
                    end else if (hdr_last) begin
                        cnt_q <= '0;
                        if (hdr_ok) begin
                            state_q <= KEY;
                        end else begin
                            state_q   <= WAIT_LOW;
                            busy_q    <= 1'b0;
                            hdr_err_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                KEY: begin
                    if (!bus.en) begin
                        state_q       <= IDLE;
                        cnt_q         <= '0;
                        busy_q        <= 1'b0;
                        frame_abort_q <= 1'b1;
                    end else if (key_last) begin
                        state_q     <= HOLD;
                        cnt_q       <= '0;
                        key_q       <= key_full;
                        key_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                HOLD: begin
                    // en is deliberately ignored here: the key stays offered until accepted.
                    if (bus.key_ready) begin
                        state_q     <= WAIT_LOW;
                        key_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
`ifdef PMU_KEY_ZEROIZE_EN
                        key_q       <= '0;
`endif
                    end
                end
                WAIT_LOW: begin
                    if (!bus.en) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    cnt_q       <= '0;
                    key_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.key_o       = key_q;
    assign bus.key_valid   = key_valid_q;
    assign bus.busy        = busy_q;
    assign bus.hdr_err     = hdr_err_q;
    assign bus.frame_abort = frame_abort_q;

endmodule

// File: tb/tb_pmu_key_deserializer.sv
// Directed/randomized bench for pmu_key_deserializer against a frame-level model of expected key delivery.
module tb_pmu_key_deserializer;

    localparam int HW = 32;
    localparam int KW = 256;
    localparam int FW = HW + KW;
`ifdef PMU_KEY_ZEROIZE_EN
    localparam bit ZEROIZE = 1'b1;
`else
    localparam bit ZEROIZE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pmu_key_if #(.KEY_WIDTH(KW)) bus ();

    pmu_key_deserializer #(
        .HEADER_WIDTH (HW),
        .KEY_WIDTH    (KW),
        .LOAD_OPCODE  (8'hA5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int nvec = 0;
    int nerr = 0;
    logic [KW-1:0] exp_key;

    task automatic chk(input string tag, input logic [KW-1:0] obs, input logic [KW-1:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk_hdr(input logic [7:0] opc, input logic [7:0] len);
        logic [31:0] r;
        r = $urandom;
        return {r[15:0], len, opc};
    endfunction

    function automatic logic [KW-1:0] rand_key();
        logic [KW-1:0] k;
        for (int i = 0; i < KW / 32; i++) k[32*i +: 32] = $urandom;
        return k;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Drives s[0..n-1] LSB first with en high; records when key_valid first appears and pulse counts.
    task automatic stream(input logic [FW-1:0] s, input int n, output int first_vld,
                          output int n_herr, output int n_abort, output logic [KW-1:0] key_seen);
        first_vld = -1;
        n_herr    = 0;
        n_abort   = 0;
        key_seen  = '0;
        for (int i = 0; i < n; i++) begin
            bus.en     = 1'b1;
            bus.data_i = s[i];
            tick();
            if (bus.key_valid === 1'b1 && first_vld < 0) begin
                first_vld = i;
                key_seen  = bus.key_o;
            end
            if (bus.hdr_err === 1'b1) n_herr++;
            if (bus.frame_abort === 1'b1) n_abort++;
        end
    endtask

    task automatic deliver(input string tag, input logic [KW-1:0] k);
        bus.key_ready = 1'b1;
        tick();
        chki({tag, "_vld_drop"}, int'(bus.key_valid), 0);
        exp_key = ZEROIZE ? '0 : k;
        chk({tag, "_key_after"}, bus.key_o, exp_key);
        bus.key_ready = 1'b0;
        bus.en        = 1'b0;
        tick();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_key"}, bus.key_o, '0);
        chki({tag, "_vld"}, int'(bus.key_valid), 0);
        chki({tag, "_busy"}, int'(bus.busy), 0);
        chki({tag, "_herr"}, int'(bus.hdr_err), 0);
        chki({tag, "_abort"}, int'(bus.frame_abort), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [KW-1:0] k, k2, ks;
        logic [31:0]   h;
        int fv, ne, na;

        rst = 1'b1;
        bus.en = 1'b0;
        bus.data_i = 1'b0;
        bus.key_ready = 1'b0;
        exp_key = '0;
        repeat (4) tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();

        // Happy path with the fixed pattern and a trailing extra bit
        k = {4{64'h0123_4567_89AB_CDEF}};
        h = 32'h0000_08A5;
        bus.key_ready = 1'b1;
        stream({k, h}, FW, fv, ne, na, ks);
        chki("hp_latency", fv, FW - 1);
        chk("hp_key", ks, k);
        chki("hp_herr", ne, 0);
        chki("hp_abort", na, 0);
        chki("hp_busy", int'(bus.busy), 1);
        bus.data_i = 1'b1;
        tick();
        chki("hp_vld_drop", int'(bus.key_valid), 0);
        exp_key = ZEROIZE ? '0 : k;
        chk("hp_key_after", bus.key_o, exp_key);
        chki("hp_busy_after", int'(bus.busy), 0);
        bus.en = 1'b0;
        bus.key_ready = 1'b0;
        tick();

        // Backpressure: key held while key_ready low, en dropped during hold
        k = rand_key();
        stream({k, mk_hdr(8'hA5, 8'd8)}, FW, fv, ne, na, ks);
        chki("bp_latency", fv, FW - 1);
        chk("bp_key", ks, k);
        bus.en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chki("bp_vld_hold", int'(bus.key_valid), 1);
            chk("bp_key_stable", bus.key_o, k);
            chki("bp_no_abort", int'(bus.frame_abort), 0);
        end
        deliver("bp", k);

        // Bad opcode with en held high: following frame must be ignored until en goes low
        stream({rand_key(), mk_hdr(8'h5A, 8'd8)}, FW, fv, ne, na, ks);
        chki("bo_herr", ne, 1);
        chki("bo_no_vld", fv, -1);
        chk("bo_key_kept", bus.key_o, exp_key);
        stream({rand_key(), mk_hdr(8'hA5, 8'd8)}, FW, fv, ne, na, ks);
        chki("wl_no_vld", fv, -1);
        chki("wl_no_herr", ne, 0);
        chk("wl_key_kept", bus.key_o, exp_key);
        bus.en = 1'b0;
        tick();
        k = rand_key();
        stream({k, mk_hdr(8'hA5, 8'd8)}, FW, fv, ne, na, ks);
        chki("bo_next_latency", fv, FW - 1);
        chk("bo_next_key", ks, k);
        deliver("bo_next", k);

        // Bad length; en falls straight after the header, which is not an abort
        stream({rand_key(), mk_hdr(8'hA5, 8'h04)}, HW, fv, ne, na, ks);
        chki("bl_herr", ne, 1);
        bus.en = 1'b0;
        tick();
        chki("bl_no_abort", int'(bus.frame_abort), 0);
        chki("bl_busy", int'(bus.busy), 0);
        chk("bl_key_kept", bus.key_o, exp_key);

        // Truncated frame after 100 key bits
        stream({rand_key(), mk_hdr(8'hA5, 8'd8)}, HW + 100, fv, ne, na, ks);
        chki("tr_no_vld", fv, -1);
        bus.en = 1'b0;
        tick();
        chki("tr_abort", int'(bus.frame_abort), 1);
        chki("tr_vld", int'(bus.key_valid), 0);
        chki("tr_busy", int'(bus.busy), 0);
        chk("tr_key_kept", bus.key_o, exp_key);
        tick();
        chki("tr_abort_pulse", int'(bus.frame_abort), 0);
        k = rand_key();
        stream({k, mk_hdr(8'hA5, 8'd8)}, FW, fv, ne, na, ks);
        chki("tr_next_latency", fv, FW - 1);
        chk("tr_next_key", ks, k);
        deliver("tr_next", k);

        // Abort inside the header
        stream({rand_key(), mk_hdr(8'hA5, 8'd8)}, 10, fv, ne, na, ks);
        bus.en = 1'b0;
        tick();
        chki("ha_abort", int'(bus.frame_abort), 1);
        chk("ha_key_kept", bus.key_o, exp_key);

        // Reset at key bit 50, then reset while holding a key
        k2 = rand_key();
        stream({k2, mk_hdr(8'hA5, 8'd8)}, HW + 50, fv, ne, na, ks);
        rst = 1'b1;
        bus.en = 1'b0;
        tick();
        chk_all_zero("rst_key");
        rst = 1'b0;
        exp_key = '0;
        tick();
        k = rand_key();
        stream({k, mk_hdr(8'hA5, 8'd8)}, FW, fv, ne, na, ks);
        chki("rh_latency", fv, FW - 1);
        rst = 1'b1;
        bus.key_ready = 1'b1;
        bus.en = 1'b0;
        tick();
        chk_all_zero("rst_hold");
        rst = 1'b0;
        bus.key_ready = 1'b0;
        tick();

        // Final load with random key after resets
        k = rand_key();
        stream({k, mk_hdr(8'hA5, 8'd8)}, FW, fv, ne, na, ks);
        chki("fin_latency", fv, FW - 1);
        chk("fin_key", ks, k);
        deliver("fin", k);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
